// File: rtl/pipe_stage_skid.sv
// Pipeline stage register with valid/ready handshake and a 2-entry skid buffer.
// Flush inserts a bubble; control bits never leave the stage while it is empty.
module pipe_stage_skid #(
   parameter int unsigned DATA_W      = 32,
   parameter int unsigned CTRL_W      = 4,
   parameter bit          CLEAR_DATA  = 1'b1,
   parameter int unsigned STALL_CNT_W = 8
) (
   input  logic                   i_clk,
   input  logic                   i_rst_n,
   input  logic                   i_flush,
   input  logic                   i_in_valid,
   output logic                   o_in_ready,
   input  logic [DATA_W-1:0]      i_in_data,
   input  logic [CTRL_W-1:0]      i_in_ctrl,
   output logic                   o_out_valid,
   input  logic                   i_out_ready,
   output logic [DATA_W-1:0]      o_out_data,
   output logic [CTRL_W-1:0]      o_out_ctrl,
   output logic [STALL_CNT_W-1:0] o_stall_cnt
);

   typedef enum logic [1:0] {StEmpty = 2'd0, StBusy = 2'd1, StFull = 2'd2} state_e;

   state_e                   r_state, w_state_d;
   logic                     r_in_ready, w_in_ready_d;
   logic [DATA_W-1:0]        r_main_data, w_main_data_d;
   logic [DATA_W-1:0]        r_skid_data, w_skid_data_d;
   logic [CTRL_W-1:0]        r_main_ctrl, w_main_ctrl_d;
   logic [CTRL_W-1:0]        r_skid_ctrl, w_skid_ctrl_d;
   logic [STALL_CNT_W-1:0]   r_stall_cnt, w_stall_cnt_d;
   logic                     w_out_valid;
   logic                     w_accept;
   logic                     w_emit;

   assign w_out_valid = (r_state != StEmpty);
   assign w_accept    = i_in_valid & r_in_ready;
   assign w_emit      = w_out_valid & i_out_ready;

   always_comb begin
      w_state_d     = r_state;
      w_main_data_d = r_main_data;
      w_main_ctrl_d = r_main_ctrl;
      w_skid_data_d = r_skid_data;
      w_skid_ctrl_d = r_skid_ctrl;
      w_stall_cnt_d = r_stall_cnt;

      case (r_state)
         StEmpty: begin
            if (w_accept) begin
               w_state_d     = StBusy;
               w_main_data_d = i_in_data;
               w_main_ctrl_d = i_in_ctrl;
            end
         end
         StBusy: begin
            if (w_accept && w_emit) begin
               w_main_data_d = i_in_data;
               w_main_ctrl_d = i_in_ctrl;
            end else if (w_accept) begin
               w_state_d     = StFull;
               w_skid_data_d = i_in_data;
               w_skid_ctrl_d = i_in_ctrl;
            end else if (w_emit) begin
               w_state_d     = StEmpty;
               w_main_ctrl_d = '0;
            end
         end
         StFull: begin
            // in_ready is low here, so only the skid-to-main move is possible
            if (w_emit) begin
               w_state_d     = StBusy;
               w_main_data_d = r_skid_data;
               w_main_ctrl_d = r_skid_ctrl;
               w_skid_ctrl_d = '0;
            end
         end
         default: begin
            w_state_d     = StEmpty;
            w_main_ctrl_d = '0;
            w_skid_ctrl_d = '0;
         end
      endcase

      if (i_flush) begin
         w_state_d     = StEmpty;
         w_main_ctrl_d = '0;
         w_skid_ctrl_d = '0;
         if (CLEAR_DATA) begin
            w_main_data_d = '0;
            w_skid_data_d = '0;
         end
      end

      w_in_ready_d = (w_state_d != StFull);

      if (w_out_valid && !i_out_ready && (r_stall_cnt != {STALL_CNT_W{1'b1}})) begin
         w_stall_cnt_d = r_stall_cnt + STALL_CNT_W'(1);
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state     <= StEmpty;
         r_in_ready  <= 1'b1;
         r_main_data <= '0;
         r_main_ctrl <= '0;
         r_skid_data <= '0;
         r_skid_ctrl <= '0;
         r_stall_cnt <= '0;
      end else begin
         r_state     <= w_state_d;
         r_in_ready  <= w_in_ready_d;
         r_main_data <= w_main_data_d;
         r_main_ctrl <= w_main_ctrl_d;
         r_skid_data <= w_skid_data_d;
         r_skid_ctrl <= w_skid_ctrl_d;
         r_stall_cnt <= w_stall_cnt_d;
      end
   end

   assign o_in_ready  = r_in_ready;
   assign o_out_valid = w_out_valid;
   assign o_out_data  = r_main_data;
   assign o_out_ctrl  = r_main_ctrl & {CTRL_W{w_out_valid}};
   assign o_stall_cnt = r_stall_cnt;

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Self-checking bench for pipe_stage_skid: vector table for handshake corners,
// queue reference model for streaming and random traffic.
module tb_pipe_stage_skid;

   localparam int unsigned DW  = 32;
   localparam int unsigned CW  = 4;
   localparam int unsigned SW  = 4;
   localparam int unsigned SMAX = 15;

   logic          clk;
   logic          rst_n;
   logic          flush;
   logic          in_valid;
   logic          in_ready;
   logic [DW-1:0] in_data;
   logic [CW-1:0] in_ctrl;
   logic          out_valid;
   logic          out_ready;
   logic [DW-1:0] out_data;
   logic [CW-1:0] out_ctrl;
   logic [SW-1:0] stall_cnt;

   pipe_stage_skid #(
      .DATA_W      (DW),
      .CTRL_W      (CW),
      .CLEAR_DATA  (1'b1),
      .STALL_CNT_W (SW)
   ) u_dut (
      .i_clk       (clk),
      .i_rst_n     (rst_n),
      .i_flush     (flush),
      .i_in_valid  (in_valid),
      .o_in_ready  (in_ready),
      .i_in_data   (in_data),
      .i_in_ctrl   (in_ctrl),
      .o_out_valid (out_valid),
      .i_out_ready (out_ready),
      .o_out_data  (out_data),
      .o_out_ctrl  (out_ctrl),
      .o_stall_cnt (stall_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      bit          iv;
      logic [31:0] din;
      logic [3:0]  cin;
      bit          ordy;
      bit          fl;
      bit          ev;
      bit          er;
      logic [31:0] ed;
      logic [3:0]  ec;
   } vec_t;

   typedef struct packed {
      logic [3:0]  ctrl;
      logic [31:0] data;
   } item_t;

   vec_t  vecs[11];
   item_t q[$];
   bit    m_rdy;
   int    m_stall;
   int    n_chk  = 0;
   int    n_pass = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
      else n_pass++;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = '0; in_ctrl = '0;
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      q.delete();
      m_rdy   = 1'b1;
      m_stall = 0;
   endtask

   // One cycle against the queue model; acc reports whether the offer was taken.
   task automatic mcycle(input bit iv, input logic [31:0] d, input logic [3:0] c,
                         input bit ordy, input bit fl, output bit acc);
      bit emit;
      in_valid = iv; in_data = d; in_ctrl = c; out_ready = ordy; flush = fl;
      check("out_valid", 64'(out_valid), 64'(q.size() > 0));
      check("in_ready", 64'(in_ready), 64'(m_rdy));
      check("stall_cnt", 64'(stall_cnt), 64'(m_stall));
      if (q.size() > 0) begin
         check("out_data", 64'(out_data), 64'(q[0].data));
         check("out_ctrl", 64'(out_ctrl), 64'(q[0].ctrl));
      end else begin
         check("ctrl_idle", 64'(out_ctrl), 64'(0));
      end
      acc  = iv && m_rdy;
      emit = (q.size() > 0) && ordy;
      if (q.size() > 0 && !ordy && m_stall < SMAX) m_stall++;
      if (fl) begin
         q.delete();
      end else begin
         if (emit) void'(q.pop_front());
         if (acc) q.push_back(item_t'{c, d});
      end
      m_rdy = (q.size() < 2);
      tick();
   endtask

   initial begin
      bit          acc;
      bit          pv;
      logic [31:0] pd;
      logic [3:0]  pc;

      vecs[0]  = '{1'b1, 32'hA, 4'h1, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0, 4'h0};
      vecs[1]  = '{1'b1, 32'hB, 4'h2, 1'b0, 1'b0, 1'b1, 1'b1, 32'hA, 4'h1};
      vecs[2]  = '{1'b0, 32'h0, 4'h0, 1'b0, 1'b0, 1'b1, 1'b0, 32'hA, 4'h1};
      vecs[3]  = '{1'b0, 32'h0, 4'h0, 1'b1, 1'b0, 1'b1, 1'b0, 32'hA, 4'h1};
      vecs[4]  = '{1'b0, 32'h0, 4'h0, 1'b1, 1'b0, 1'b1, 1'b1, 32'hB, 4'h2};
      vecs[5]  = '{1'b0, 32'h0, 4'h0, 1'b1, 1'b0, 1'b0, 1'b1, 32'hB, 4'h0};
      vecs[6]  = '{1'b1, 32'hC, 4'h4, 1'b0, 1'b0, 1'b0, 1'b1, 32'hB, 4'h0};
      vecs[7]  = '{1'b1, 32'hD, 4'h8, 1'b0, 1'b0, 1'b1, 1'b1, 32'hC, 4'h4};
      vecs[8]  = '{1'b1, 32'hE, 4'hF, 1'b0, 1'b1, 1'b1, 1'b0, 32'hC, 4'h4};
      vecs[9]  = '{1'b0, 32'h0, 4'h0, 1'b1, 1'b0, 1'b0, 1'b1, 32'h0, 4'h0};
      vecs[10] = '{1'b0, 32'h0, 4'h0, 1'b1, 1'b0, 1'b0, 1'b1, 32'h0, 4'h0};

      // Asynchronous reset while an item is held and stalled
      do_reset();
      in_valid = 1'b1; in_data = 32'h55; in_ctrl = 4'h3; out_ready = 1'b0;
      tick();
      in_valid = 1'b0;
      tick();
      check("pre_rst_valid", 64'(out_valid), 64'(1));
      check("pre_rst_stall", 64'(stall_cnt), 64'(1));
      #3;
      rst_n = 1'b0;
      #1;
      check("rst_out_valid", 64'(out_valid), 64'(0));
      check("rst_out_ctrl", 64'(out_ctrl), 64'(0));
      check("rst_out_data", 64'(out_data), 64'(0));
      check("rst_in_ready", 64'(in_ready), 64'(1));
      check("rst_stall", 64'(stall_cnt), 64'(0));

      // Back-pressure into FULL, drain, then flush from FULL
      do_reset();
      for (int i = 0; i < 11; i++) begin
         in_valid = vecs[i].iv; in_data = vecs[i].din; in_ctrl = vecs[i].cin;
         out_ready = vecs[i].ordy; flush = vecs[i].fl;
         check($sformatf("vec%0d_valid", i), 64'(out_valid), 64'(vecs[i].ev));
         check($sformatf("vec%0d_ready", i), 64'(in_ready), 64'(vecs[i].er));
         check($sformatf("vec%0d_data", i), 64'(out_data), 64'(vecs[i].ed));
         check($sformatf("vec%0d_ctrl", i), 64'(out_ctrl), 64'(vecs[i].ec));
         tick();
      end
      flush = 1'b0;

      // Stall counter saturation, untouched by flush
      do_reset();
      in_valid = 1'b1; in_data = 32'h77; in_ctrl = 4'h1; out_ready = 1'b0;
      tick();
      in_valid = 1'b0;
      for (int i = 1; i <= 20; i++) begin
         tick();
         if (i == 10) check("stall_10", 64'(stall_cnt), 64'(10));
      end
      check("stall_sat", 64'(stall_cnt), 64'(SMAX));
      flush = 1'b1;
      tick();
      flush = 1'b0;
      check("stall_flush", 64'(stall_cnt), 64'(SMAX));
      check("flush_valid", 64'(out_valid), 64'(0));
      tick();
      check("stall_hold", 64'(stall_cnt), 64'(SMAX));

      // Full-throughput streaming
      do_reset();
      for (int i = 0; i < 16; i++) mcycle(1'b1, 32'h10 + 32'(i), 4'(i), 1'b1, 1'b0, acc);
      for (int i = 0; i < 3; i++) mcycle(1'b0, 32'h0, 4'h0, 1'b1, 1'b0, acc);

      // Random traffic with a producer that holds its offer until taken
      do_reset();
      pv = 1'b0; pd = '0; pc = '0;
      for (int i = 0; i < 10000; i++) begin
         bit ordy;
         bit fl;
         if (!pv && $urandom_range(0, 99) < 70) begin
            pv = 1'b1;
            pd = $urandom();
            pc = 4'($urandom());
         end
         ordy = ($urandom_range(0, 99) < 60);
         fl   = ($urandom_range(0, 99) < 3);
         mcycle(pv, pd, pc, ordy, fl, acc);
         if (acc || fl) pv = 1'b0;
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
